// File: rtl/chroma_pkg.sv
// Shared constants and types for the 4:2:0 -> 4:4:4 chroma upsampler.
package chroma_pkg;

    localparam int unsigned Y_BEATS   = 256;
    localparam int unsigned C_BEATS   = 64;
    localparam int unsigned IN_BEATS  = 384;
    localparam int unsigned OUT_BEATS = 768;
    localparam int unsigned MCU_DIM   = 16;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned Y_IDX_W = 8;
    localparam int unsigned C_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        SEND    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PLANE_Y  = 2'd0,
        PLANE_CB = 2'd1,
        PLANE_CR = 2'd2,
        PLANE_NA = 2'd3
    } plane_t;

endpackage

// File: rtl/chroma_up_addr_map.sv
// Maps the output beat counter to a plane select and buffer read indices.
// A chroma sample at (row, col) of the 16x16 plane comes from the 8x8
// buffer at (row/2, col/2), giving 2x2 nearest-neighbour replication.
module chroma_up_addr_map
    import chroma_pkg::*;
(
    input  logic [CNT_W-1:0]   out_cnt,
    output plane_t             plane,
    output logic [Y_IDX_W-1:0] y_idx,
    output logic [C_IDX_W-1:0] c_idx
);

    // Pure bit slicing: plane from the top bits, {row[3:1], col[3:1]} for chroma
    always_comb begin
        plane = plane_t'(out_cnt[9:8]);
        y_idx = out_cnt[7:0];
        c_idx = {out_cnt[7:5], out_cnt[3:1]};
    end

endmodule

// File: rtl/chroma_upsampling.sv
// 4:2:0 -> 4:4:4 chroma upsampler for one 16x16 MCU.
// Buffers 256 Y + 64 Cb + 64 Cr input bytes, then streams 768 bytes
// (Y, Cb, Cr planes, each 16x16 raster) with chroma replicated 2x2.
// Optional macro CHROMA_UP_FRAMING_CHECK_EN adds a sticky err_framing
// output flagging s_axis_tlast disagreeing with the beat count.
module chroma_upsampling
    import chroma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef CHROMA_UP_FRAMING_CHECK_EN
    ,
    output logic                  err_framing
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic [DATA_WIDTH-1:0] y_buf  [Y_BEATS];
    logic [DATA_WIDTH-1:0] cb_buf [C_BEATS];
    logic [DATA_WIDTH-1:0] cr_buf [C_BEATS];

    logic                  in_hs, out_hs;
    logic                  y_we, cb_we, cr_we;
    logic [Y_IDX_W-1:0]    y_waddr;
    logic [C_IDX_W-1:0]    cb_waddr, cr_waddr;
    logic                  in_last, out_last;

    plane_t                rd_plane;
    logic [Y_IDX_W-1:0]    rd_y_idx;
    logic [C_IDX_W-1:0]    rd_c_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    chroma_up_addr_map u_addr_map (
        .out_cnt (out_cnt_q),
        .plane   (rd_plane),
        .y_idx   (rd_y_idx),
        .c_idx   (rd_c_idx)
    );

    // Handshakes and buffer write decode from the input beat count
    always_comb begin
        in_hs    = (state_q == RECEIVE) && s_axis_tvalid;
        out_hs   = (state_q == SEND) && m_axis_tready;
        in_last  = (in_cnt_q == CNT_W'(IN_BEATS - 1));
        out_last = (out_cnt_q == CNT_W'(OUT_BEATS - 1));
        y_we     = in_hs && (in_cnt_q < CNT_W'(Y_BEATS));
        cb_we    = in_hs && (in_cnt_q >= CNT_W'(Y_BEATS))
                         && (in_cnt_q < CNT_W'(Y_BEATS + C_BEATS));
        cr_we    = in_hs && (in_cnt_q >= CNT_W'(Y_BEATS + C_BEATS));
        y_waddr  = Y_IDX_W'(in_cnt_q);
        cb_waddr = C_IDX_W'(in_cnt_q - CNT_W'(Y_BEATS));
        cr_waddr = C_IDX_W'(in_cnt_q - CNT_W'(Y_BEATS + C_BEATS));
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            IDLE: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                state_d   = RECEIVE;
            end
            RECEIVE: begin
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Sample buffers; contents are don't-care after reset
    always_ff @(posedge aclk) begin
        if (y_we)  y_buf[y_waddr]   <= s_axis_tdata;
        if (cb_we) cb_buf[cb_waddr] <= s_axis_tdata;
        if (cr_we) cr_buf[cr_waddr] <= s_axis_tdata;
    end

    // Output mux, forced to zero outside SEND
    always_comb begin
        rd_data = '0;
        case (rd_plane)
            PLANE_Y:  rd_data = y_buf[rd_y_idx];
            PLANE_CB: rd_data = cb_buf[rd_c_idx];
            PLANE_CR: rd_data = cr_buf[rd_c_idx];
            default:  rd_data = '0;
        endcase
        s_axis_tready = (state_q == RECEIVE);
        m_axis_tvalid = (state_q == SEND);
        m_axis_tdata  = (state_q == SEND) ? rd_data : '0;
        m_axis_tlast  = (state_q == SEND) && out_last;
    end

`ifdef CHROMA_UP_FRAMING_CHECK_EN
    logic err_framing_q, err_framing_d;

    // Sticky flag: tlast must be set exactly on the final counted input beat
    always_comb begin
        err_framing_d = err_framing_q;
        if (in_hs && (s_axis_tlast != in_last)) begin
            err_framing_d = 1'b1;
        end
    end

    // Framing error register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_framing_q <= 1'b0;
        end else begin
            err_framing_q <= err_framing_d;
        end
    end

    assign err_framing = err_framing_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

endmodule

// File: doc/chroma_upsampling.md
Name: chroma_upsampling

Overview:
- Decoder-side 4:2:0 → 4:4:4 chroma reconstruction for one 16x16 MCU.
- Input stream: 384 bytes in planar order: 256 Y, then 64 Cb (8x8), then 64 Cr (8x8).
- Output stream: 768 bytes in planar order: 256 Y, 256 Cb, 256 Cr, each plane 16x16 raster.
- Each chroma sample is replicated into its 2x2 block (nearest neighbour). The block sits between the JPEG decode path's inverse colour-plane stage and the YCbCr→RGB converter.

Parameters:
- DATA_WIDTH, 8, width of each sample and of both tdata buses.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_WIDTH  input sample.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block accepts input.
- s_axis_tlast  in  1  marks the last input beat (beat 383).
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  downstream accepts output.
- m_axis_tlast  out  1  marks the last output beat (beat 767).

Behaviour:
- Reset is asynchronous and active-high; one clock.
- While areset is high:
  - state = IDLE, in_cnt = 0, out_cnt = 0.
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
- Outputs decode from registered state, so they drop in the same instant areset rises.
- FSM states:
  - IDLE: clears both counters; goes to RECEIVE after one cycle.
  - RECEIVE: s_axis_tready = 1. On each handshake:
    - in_cnt 0..255 → y_buf[in_cnt]
    - in_cnt 256..319 → cb_buf[in_cnt-256]
    - in_cnt 320..383 → cr_buf[in_cnt-320]
    - in_cnt increments (10-bit).
    - The handshake at in_cnt == 383 moves the FSM to SEND.
    - s_axis_tlast does not end the frame; only the count does.
  - SEND: m_axis_tvalid = 1. out_cnt (10-bit, 0..767) selects the output:
    - plane = out_cnt[9:8] (0 = Y, 1 = Cb, 2 = Cr).
    - p = out_cnt[7:0], row r = p[7:4], col c = p[3:0].
    - Y: m_axis_tdata = y_buf[p].
    - Cb/Cr: m_axis_tdata = plane_buf[{r[3:1], c[3:1]}] (6-bit index).
    - m_axis_tlast = (out_cnt == 767).
    - Each handshake increments out_cnt. The handshake at 767 moves the FSM to IDLE.
- Outside SEND, m_axis_tdata = 0 and m_axis_tlast = 0.
- Latency:
  - First output beat is valid in the cycle after the beat-383 input handshake.
  - No input is accepted from then until IDLE completes.
  - Minimum period per MCU is 384 + 768 + 1 cycles.
- Handshake rules:
  - While m_axis_tvalid = 1 and tready = 0, tdata and tlast hold stable.
  - tvalid never drops until the handshake.
  - Input gaps (s_axis_tvalid low) only stall in_cnt.
- No arithmetic is performed; samples pass through unmodified at full DATA_WIDTH.
- Reset mid-operation: all partial data is abandoned; buffer contents are don't-care. After release: one IDLE cycle, then RECEIVE with in_cnt = 0.

Optional Feature:
- Macro CHROMA_UP_FRAMING_CHECK_EN.
- When defined:
  - Adds output port err_framing (1 bit), reset to 0.
  - err_framing goes to 1 and stays there (sticky until areset) if either:
    - s_axis_tlast = 1 on an accepted beat with in_cnt != 383, or
    - s_axis_tlast = 0 on the accepted beat with in_cnt == 383.
  - Data flow is unchanged; the count still governs framing.
- When undefined: no port, and s_axis_tlast is ignored.

Decomposition:
- Package chroma_pkg holds:
  - constants: Y_BEATS = 256, C_BEATS = 64, IN_BEATS = 384, OUT_BEATS = 768, MCU_DIM = 16;
  - state enum: IDLE, RECEIVE, SEND.
- One natural sub-module: chroma_up_addr_map. It is combinational and maps out_cnt to a plane select and an 8-bit Y or 6-bit chroma buffer index, so it can be unit-tested exhaustively.
- Buffers and FSM stay in the top module.

Test Plan:
- Data mapping:
  - Stimulus: Y = 0..255, Cb[i] = i, Cr[i] = 100 + i.
  - Response: out 0..255 = 0..255.
  - Cb plane outputs:
    - out 256 and 257 = 0;
    - out 272 (r1,c0) = 0;
    - out 258 = 1;
    - out 511 = 63.
  - Cr plane outputs:
    - out 512 = 100;
    - out 767 = 163;
    - tlast only on beat 767.
- Output backpressure: m_axis_tready toggles 1,0,1,0 → identical 768-byte sequence; tdata held stable while stalled.
- Input gaps and boundary:
  - Stimulus: s_axis_tvalid random at 50%.
  - Response: correct output; s_axis_tready falls the cycle after beat 383 and rises again one cycle after the beat-767 output handshake.
- Back-to-back MCUs: frame A (all 0x10), then frame B (all 0xEF) → 768 × 0x10, then 768 × 0xEF, with no mixing.
- Reset mid-stream:
  - Stimulus: areset asserted during SEND at out_cnt = 300.
  - Response: m_axis_tvalid drops immediately.
  - After release: one cycle tready = 0 (IDLE), then tready = 1. A fresh frame outputs correctly.
- With CHROMA_UP_FRAMING_CHECK_EN:
  - tlast on beat 100 → err_framing = 1 from the next cycle; it stays 1 through the full frame and the next clean frame.
  - Clean frame after reset → err_framing stays 0.
